// File: rtl/complex_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined complex adder/subtractor.
// The slave modport is the block's view; the master modport is the driver's view.
interface complex_addsub_pipe_if #(
    parameter int DATA_W = 16
);
    logic              i_valid;
    logic              o_ready;
    logic              i_sub;
    logic [DATA_W-1:0] i_data_ra;
    logic [DATA_W-1:0] i_data_ca;
    logic [DATA_W-1:0] i_data_rb;
    logic [DATA_W-1:0] i_data_cb;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data_r;
    logic [DATA_W-1:0] o_data_c;
    logic              i_clr_ovf;
    logic              o_ovf;

    modport slave (
        input  i_valid, i_sub, i_data_ra, i_data_ca, i_data_rb, i_data_cb,
        input  i_ready, i_clr_ovf,
        output o_ready, o_valid, o_data_r, o_data_c, o_ovf
    );

    modport master (
        output i_valid, i_sub, i_data_ra, i_data_ca, i_data_rb, i_data_cb,
        output i_ready, i_clr_ovf,
        input  o_ready, o_valid, o_data_r, o_data_c, o_ovf
    );
endinterface

// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex adder/subtractor for the FFT datapath.
// Stage 1 holds the full-precision (DATA_W+1 bit) sum/difference; stage 2
// holds the scaled, saturated or wrapped DATA_W result. Both stages stall
// together whenever the output is valid and downstream is not ready.
module complex_addsub_pipe #(
    parameter int DATA_W = 16,
    parameter int SCALE  = 0,
    parameter int SAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    complex_addsub_pipe_if.slave bus
);

    logic                     en;
    logic signed [DATA_W:0]   a_r, a_c, b_r, b_c;
    logic signed [DATA_W:0]   sum_r, sum_c;
    logic                     s1_valid;
    logic        [DATA_W:0]   s1_r, s1_c;
    logic        [DATA_W:0]   post_r, post_c;

    // Returns {ovf, result}: arithmetic halving when scaling, otherwise
    // range check followed by clamp or wrap.
    function automatic logic [DATA_W:0] post_proc(input logic [DATA_W:0] full);
        logic              ovf;
        logic [DATA_W-1:0] res;
        ovf = 1'b0;
        res = full[DATA_W-1:0];
        if (SCALE != 0) begin
            res = full[DATA_W:1];
        end else begin
            ovf = full[DATA_W] ^ full[DATA_W-1];
            if (ovf && (SAT != 0)) begin
                res = full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
        return {ovf, res};
    endfunction

    assign en          = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = en;

    // Sign-extend operands and form full-precision sum or difference.
    always_comb begin
        a_r   = {bus.i_data_ra[DATA_W-1], bus.i_data_ra};
        a_c   = {bus.i_data_ca[DATA_W-1], bus.i_data_ca};
        b_r   = {bus.i_data_rb[DATA_W-1], bus.i_data_rb};
        b_c   = {bus.i_data_cb[DATA_W-1], bus.i_data_cb};
        sum_r = bus.i_sub ? (a_r - b_r) : (a_r + b_r);
        sum_c = bus.i_sub ? (a_c - b_c) : (a_c + b_c);
    end

    // Stage 1: capture the full-precision result; a bubble loads when no sample is offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_c     <= '0;
        end else if (en) begin
            s1_valid <= bus.i_valid;
            s1_r     <= sum_r;
            s1_c     <= sum_c;
        end
    end

    // Range handling of the stage-1 contents, feeding stage 2.
    always_comb begin
        post_r = post_proc(s1_r);
        post_c = post_proc(s1_c);
    end

    // Stage 2: output registers and output valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_valid  <= 1'b0;
            bus.o_data_r <= '0;
            bus.o_data_c <= '0;
        end else if (en) begin
            bus.o_valid  <= s1_valid;
            bus.o_data_r <= post_r[DATA_W-1:0];
            bus.o_data_c <= post_c[DATA_W-1:0];
        end
    end

    // Sticky overflow: a valid overflowing sample entering stage 2 beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_ovf <= 1'b0;
        end else if (en && s1_valid && (post_r[DATA_W] || post_c[DATA_W])) begin
            bus.o_ovf <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            bus.o_ovf <= 1'b0;
        end
    end

endmodule

// File: doc/complex_addsub_pipe.md
Name: complex_addsub_pipe

Overview:
Parametrised, pipelined complex adder/subtractor: the next generation of the team's single-cycle complex adder for the FFT datapath. It computes A+B or A−B per sample on signed two's-complement operands and offers optional divide-by-2 scaling and saturation. A valid/ready handshake with full-pipeline stall lets it sit between butterfly stages that apply backpressure. A sticky overflow flag reports range violations.

Parameters:
DATA_W, 16, operand and result width in bits (signed two's complement), legal range 4..32
SCALE, 0, 1 = arithmetic shift right by 1 of the full-precision result (FFT stage scaling); 0 = no scaling
SAT, 1, 1 = clamp out-of-range results to max/min; 0 = wrap (keep low DATA_W bits); ignored when SCALE=1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
i_valid  input  1  input sample valid
o_ready  output  1  block can accept a sample this cycle
i_sub  input  1  0 = A+B, 1 = A−B; sampled with the data
i_data_ra  input  DATA_W  real part of A
i_data_ca  input  DATA_W  imaginary part of A
i_data_rb  input  DATA_W  real part of B
i_data_cb  input  DATA_W  imaginary part of B
o_valid  output  1  output sample valid
i_ready  input  1  downstream accepts the output this cycle
o_data_r  output  DATA_W  real result
o_data_c  output  DATA_W  imaginary result
i_clr_ovf  input  1  synchronous clear of o_ovf
o_ovf  output  1  sticky overflow flag

Behaviour:
- Reset (async, active-high): o_valid=0, o_data_r=0, o_data_c=0, o_ovf=0, both stage valid bits 0; in-flight samples are discarded. o_ready=1 immediately after reset.
- Pipeline: stage 1 registers the sign-extended DATA_W+1-bit sum/difference for real and imag, plus a stage valid bit. Stage 2 registers the scaled/saturated/wrapped DATA_W result, the per-sample overflow, and o_valid.
- Stall enable en = !o_valid || i_ready. Both stages advance only when en=1. o_ready = en (combinational). A sample is accepted when i_valid && o_ready.
- Latency is 2 clocks from acceptance to o_valid with i_ready held high. Throughput is 1 sample/clock. Bubbles propagate as invalid stages.
- While stalled (o_valid=1, i_ready=0), o_data_*, o_valid and stage-1 contents hold constant. No loss, duplication or reordering.
- Arithmetic: full = sext(a) ± sext(b), computed at DATA_W+1 bits, independently for real and imag.
  - SCALE=1: result = full >>> 1 (floor toward −inf). This never overflows, so ovf=0.
  - SCALE=0, in range [−2^(DATA_W−1), 2^(DATA_W−1)−1]: result = full.
  - SCALE=0, out of range: ovf=1. With SAT=1 the result clamps to max (positive overflow) or min (negative overflow). With SAT=0 the result is full[DATA_W−1:0].
- o_ovf sets on the cycle a stage-2 load captures a sample with ovf=1 on real or imag. It stays set until i_clr_ovf. If set and clear occur on the same cycle, set wins (o_ovf stays 1).
- i_sub, data and i_clr_ovf are don't-care when their qualifiers are low. Invalid stages never set o_ovf.

Test Plan:
- DATA_W=16, SCALE=0, SAT=1: A=(0x7FFF,0x0001), B=(0x0001,0x0002), add -> after 2 clocks o_valid=1, o_data_r=0x7FFF, o_data_c=0x0003, o_ovf=1 from the next edge onward.
- Same config, sub: A=(0x8000,0x0005), B=(0x0001,0x0007) -> o_data_r=0x8000 (clamped), o_data_c=0xFFFE; with SAT=0 -> o_data_r=0x7FFF (wrap), o_ovf=1.
- SCALE=1: add (3,−3)+(4,−4) -> o_data_r=3, o_data_c=−4 (0xFFFC), o_ovf stays 0. Add 0x7FFF+0x7FFF -> 0x7FFF.
- Backpressure: stream 6 samples back-to-back with i_ready pattern 1,0,0,1,0,1,1,1... -> the 6 outputs appear in order exactly once, and o_ready=0 exactly on cycles with o_valid=1 && i_ready=0.
- Flag control: cause an overflow, then pulse i_clr_ovf -> o_ovf=0. Pulse i_clr_ovf on the same cycle a new overflow sample loads -> o_ovf stays 1.
- Assert rst for 1 cycle with 2 samples in flight -> o_valid=0 and outputs 0 asynchronously. No stale samples emerge afterwards. A new sample accepted post-reset appears 2 clocks later.
